// File: rtl/data_read_pkg.sv
// Shared register-map constants and helpers for the multi-channel read-out block.
package data_read_pkg;

    // Register offsets inside one channel window
    localparam int unsigned CH_STRIDE  = 16;
    localparam logic [3:0]  OFF_DATA   = 4'h0;
    localparam logic [3:0]  OFF_STATUS = 4'h4;
    localparam logic [3:0]  OFF_CTRL   = 4'h8;
    localparam logic [3:0]  OFF_RSVD   = 4'hC;

    // STATUS bit positions (level occupies [15:0])
    localparam int unsigned STS_EMPTY_BIT = 16;
    localparam int unsigned STS_FULL_BIT  = 17;
    localparam int unsigned STS_OVF_BIT   = 18;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_IRQEN_BIT  = 1;
    localparam int unsigned CTRL_FLUSH_BIT  = 2;
    localparam int unsigned CTRL_CLROVF_BIT = 3;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    // Map the low nibble of an address onto the word it selects; byte lanes ignored
    function automatic reg_sel_e decode_reg(input logic [3:0] off);
        reg_sel_e sel;
        case ({off[3:2], 2'b00})
            OFF_DATA:   sel = REG_DATA;
            OFF_STATUS: sel = REG_STATUS;
            OFF_CTRL:   sel = REG_CTRL;
            OFF_RSVD:   sel = REG_RSVD;
            default:    sel = REG_RSVD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/data_read_fifo.sv
// Synchronous single-clock FIFO with flush; a pop and a push may share a cycle even when full.
module data_read_fifo
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [WIDTH-1:0]       din_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en_s, rd_en_s;

    assign empty_o = (count_q == (AW+1)'(0));
    // DEPTH is a power of two, so the count MSB alone marks full
    assign full_o  = count_q[AW];
    assign level_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    // Qualify push/pop; flush suppresses both, a pop frees room for a same-cycle push
    always_comb begin
        wr_en_s = 1'b0;
        rd_en_s = 1'b0;
        if (flush_i) begin
            wr_en_s = 1'b0;
            rd_en_s = 1'b0;
        end else begin
            rd_en_s = pop_i & ~empty_o;
            wr_en_s = push_i & (~full_o | rd_en_s);
        end
    end

    // Next pointer/count; pointers wrap naturally modulo DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = AW'(0);
            rd_ptr_d = AW'(0);
            count_d  = (AW+1)'(0);
        end else begin
            wr_ptr_d = wr_en_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
            rd_ptr_d = rd_en_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
            count_d  = count_q + (AW+1)'(wr_en_s) - (AW+1)'(rd_en_s);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= (AW+1)'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/data_read_axi_mch.sv
// AXI4-Lite read-out of N_CH capture FIFOs with per-channel control, sticky overflow and irq.
module data_read_axi_mch
#(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    input  logic [31:0]              S_AXI_AWADDR,
    input  logic                     S_AXI_AWVALID,
    output logic                     S_AXI_AWREADY,
    input  logic [31:0]              S_AXI_WDATA,
    input  logic [3:0]               S_AXI_WSTRB,
    input  logic                     S_AXI_WVALID,
    output logic                     S_AXI_WREADY,
    output logic [1:0]               S_AXI_BRESP,
    output logic                     S_AXI_BVALID,
    input  logic                     S_AXI_BREADY,
    input  logic [31:0]              S_AXI_ARADDR,
    input  logic                     S_AXI_ARVALID,
    output logic                     S_AXI_ARREADY,
    output logic [31:0]              S_AXI_RDATA,
    output logic [1:0]               S_AXI_RRESP,
    output logic                     S_AXI_RVALID,
    input  logic                     S_AXI_RREADY,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    input  logic [N_CH-1:0]          ch_valid,
    output logic                     irq
);
    import data_read_pkg::*;

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CH_W  = ADDR_W - 4;
    localparam logic [ADDR_W-1:0] MAP_LIMIT = ADDR_W'(N_CH * CH_STRIDE);

    // AXI handshake registers
    logic        awready_q, awready_d;
    logic        wready_q,  wready_d;
    logic        bvalid_q,  bvalid_d;
    logic [1:0]  bresp_q,   bresp_d;
    logic        arready_q, arready_d;
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;
    logic [1:0]  rresp_q,   rresp_d;
    logic        irq_q,     irq_d;

    // Per-channel control state
    logic [N_CH-1:0] enable_q, enable_d;
    logic [N_CH-1:0] irq_en_q, irq_en_d;
    logic [N_CH-1:0] ovf_q,    ovf_d;

    // Per-channel FIFO interface
    logic [N_CH-1:0]   push_s, pop_s, flush_s, clr_ovf_s;
    logic [N_CH-1:0]   fifo_empty_s, fifo_full_s;
    logic [DATA_W-1:0] fifo_dout_s  [N_CH];
    logic [LVL_W-1:0]  fifo_level_s [N_CH];

    // Address decode
    logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;
    logic [CH_W-1:0]   wr_ch_s, rd_ch_s;
    reg_sel_e          wr_reg_s, rd_reg_s;
    logic              wr_mapped_s, rd_mapped_s;
    logic              wr_hs_s, rd_hs_s, ctrl_wr_s;
    logic [31:0]       rdata_sel_s;
    logic [1:0]        rresp_sel_s;

    assign wr_addr_s   = S_AXI_AWADDR[ADDR_W-1:0];
    assign rd_addr_s   = S_AXI_ARADDR[ADDR_W-1:0];
    assign wr_ch_s     = wr_addr_s[ADDR_W-1:4];
    assign rd_ch_s     = rd_addr_s[ADDR_W-1:4];
    assign wr_reg_s    = decode_reg(wr_addr_s[3:0]);
    assign rd_reg_s    = decode_reg(rd_addr_s[3:0]);
    assign wr_mapped_s = (wr_addr_s < MAP_LIMIT);
    assign rd_mapped_s = (rd_addr_s < MAP_LIMIT);

    // Handshakes complete while the registered ready pulse meets the master's valid
    assign wr_hs_s   = awready_q & S_AXI_AWVALID & wready_q & S_AXI_WVALID;
    assign rd_hs_s   = arready_q & S_AXI_ARVALID;
    assign ctrl_wr_s = wr_hs_s & wr_mapped_s & (wr_reg_s == REG_CTRL) & S_AXI_WSTRB[0];

    logic unused_s;
    assign unused_s = ^{S_AXI_AWADDR[31:ADDR_W], S_AXI_ARADDR[31:ADDR_W],
                        S_AXI_WDATA[31:4], S_AXI_WSTRB[3:1]};

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        data_read_fifo #(
            .WIDTH (DATA_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (S_AXI_ACLK),
            .rst_n   (S_AXI_ARESETN),
            .push_i  (push_s[c]),
            .pop_i   (pop_s[c]),
            .flush_i (flush_s[c]),
            .din_i   (ch_data[c*DATA_W +: DATA_W]),
            .dout_o  (fifo_dout_s[c]),
            .level_o (fifo_level_s[c]),
            .empty_o (fifo_empty_s[c]),
            .full_o  (fifo_full_s[c])
        );
    end

    // Channel push when enabled; pop only on a DATA read handshake of a non-empty FIFO
    always_comb begin
        push_s = {N_CH{1'b0}};
        pop_s  = {N_CH{1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            push_s[c] = ch_valid[c] & enable_q[c];
            pop_s[c]  = rd_hs_s & rd_mapped_s & (rd_reg_s == REG_DATA) &
                        (rd_ch_s == CH_W'(c)) & ~fifo_empty_s[c];
        end
    end

    // CTRL writes, self-clearing flush/clr_ovf strobes and sticky overflow update
    always_comb begin
        enable_d  = enable_q;
        irq_en_d  = irq_en_q;
        ovf_d     = ovf_q;
        flush_s   = {N_CH{1'b0}};
        clr_ovf_s = {N_CH{1'b0}};
        for (int c = 0; c < N_CH; c++) begin
            if (ctrl_wr_s && (wr_ch_s == CH_W'(c))) begin
                enable_d[c]  = S_AXI_WDATA[CTRL_EN_BIT];
                irq_en_d[c]  = S_AXI_WDATA[CTRL_IRQEN_BIT];
                flush_s[c]   = S_AXI_WDATA[CTRL_FLUSH_BIT];
                clr_ovf_s[c] = S_AXI_WDATA[CTRL_CLROVF_BIT];
            end else begin
                enable_d[c]  = enable_q[c];
                irq_en_d[c]  = irq_en_q[c];
            end
            // A drop only counts when no pop makes room and no flush discards the push
            if (clr_ovf_s[c]) begin
                ovf_d[c] = 1'b0;
            end else begin
                ovf_d[c] = ovf_q[c] |
                           (push_s[c] & fifo_full_s[c] & ~pop_s[c] & ~flush_s[c]);
            end
        end
    end

    // Read-data multiplexer for the addressed channel word
    always_comb begin
        rdata_sel_s = 32'd0;
        rresp_sel_s = RESP_OKAY;
        if (!rd_mapped_s) begin
            rresp_sel_s = RESP_SLVERR;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (rd_ch_s == CH_W'(c)) begin
                    case (rd_reg_s)
                        REG_DATA: begin
                            rdata_sel_s = fifo_empty_s[c] ? 32'd0 : 32'(fifo_dout_s[c]);
                        end
                        REG_STATUS: begin
                            rdata_sel_s[15:0]          = 16'(fifo_level_s[c]);
                            rdata_sel_s[STS_EMPTY_BIT] = fifo_empty_s[c];
                            rdata_sel_s[STS_FULL_BIT]  = fifo_full_s[c];
                            rdata_sel_s[STS_OVF_BIT]   = ovf_q[c];
                        end
                        REG_CTRL: begin
                            rdata_sel_s[CTRL_EN_BIT]    = enable_q[c];
                            rdata_sel_s[CTRL_IRQEN_BIT] = irq_en_q[c];
                        end
                        default: begin
                            rdata_sel_s = 32'd0;
                        end
                    endcase
                end else begin
                    rdata_sel_s = rdata_sel_s;
                end
            end
        end
    end

    // AXI channel next-state: one write and one read outstanding at most
    always_comb begin
        awready_d = ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
        wready_d  = ~wready_q  & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        arready_d = ~arready_q & S_AXI_ARVALID & ~rvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (wr_hs_s) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_mapped_s ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end
        if (rd_hs_s) begin
            rvalid_d = 1'b1;
            rdata_d  = rdata_sel_s;
            rresp_d  = rresp_sel_s;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end else begin
            rvalid_d = rvalid_q;
        end
        irq_d = |(irq_en_q & (~fifo_empty_s | ovf_q));
    end

    // State registers, cleared asynchronously
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            irq_q     <= 1'b0;
            enable_q  <= {N_CH{1'b0}};
            irq_en_q  <= {N_CH{1'b0}};
            ovf_q     <= {N_CH{1'b0}};
        end else begin
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            irq_q     <= irq_d;
            enable_q  <= enable_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_data_read_axi_mch.sv
// Directed self-checking bench for data_read_axi_mch.
module tb_data_read_axi_mch;
    localparam int N_CH = 4;
    localparam int DATA_W = 16;
    localparam int FIFO_DEPTH = 16;
    localparam int ADDR_W = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [31:0]            awaddr, wdata, araddr;
    logic [3:0]             wstrb;
    logic                   awvalid, wvalid, bready, arvalid, rready;
    logic                   awready, wready, bvalid, arready, rvalid;
    logic [1:0]             bresp, rresp;
    logic [31:0]            rdata;
    logic [N_CH*DATA_W-1:0] ch_data;
    logic [N_CH-1:0]        ch_valid;
    logic                   irq;

    int n_total = 0;
    int n_pass  = 0;

    data_read_axi_mch #(
        .N_CH(N_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ch_data(ch_data), .ch_valid(ch_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(posedge clk); #1; n++; end
        check("wr_addr_accept", {31'd0, awready & wready}, 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 50) begin @(posedge clk); #1; n++; end
        check("wr_bvalid", {31'd0, bvalid}, 32'd1);
        resp = bresp;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        @(posedge clk); #1;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(posedge clk); #1; n++; end
        check("rd_addr_accept", {31'd0, arready}, 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
        check("rd_rvalid", {31'd0, rvalid}, 32'd1);
        data = rdata;
        resp = rresp;
    endtask

    task automatic push(input int ch, input logic [15:0] val);
        @(posedge clk); #1;
        ch_data[ch*DATA_W +: DATA_W] = val;
        ch_valid[ch] = 1'b1;
        @(posedge clk); #1;
        ch_valid = '0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          n;
        int          aw_pulses;

        rst_n = 1'b0;
        awaddr = 32'd0; wdata = 32'd0; wstrb = 4'h0; araddr = 32'd0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b1; rready = 1'b1;
        ch_data = '0; ch_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl_outs", {26'd0, awready, wready, bvalid, arready, rvalid, irq}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resps", {28'd0, bresp, rresp}, 32'd0);
        rst_n = 1'b1;

        // Empty status, unmapped read/write, reserved word
        axi_read(32'h04, d, r);
        check("ch0_status_empty", d, 32'h0001_0000);
        check("ch0_status_resp", {30'd0, r}, 32'd0);
        axi_read(32'h40, d, r);
        check("unmapped_rdata", d, 32'd0);
        check("unmapped_rresp", {30'd0, r}, 32'd2);
        axi_write(32'h40, 32'h1, 4'hF, r);
        check("unmapped_bresp", {30'd0, r}, 32'd2);
        axi_read(32'h0C, d, r);
        check("rsvd_rdata", {d[31:2], r}, 32'd0);

        // Channel 1 basic FIFO order
        axi_write(32'h18, 32'h1, 4'hF, r);
        check("ch1_ctrl_bresp", {30'd0, r}, 32'd0);
        axi_read(32'h18, d, r);
        check("ch1_ctrl_rb", d, 32'h1);
        push(1, 16'h00AA);
        push(1, 16'h00BB);
        axi_read(32'h14, d, r);
        check("ch1_status_lvl2", d, 32'h0000_0002);
        axi_read(32'h10, d, r);
        check("ch1_data0", d, 32'h0000_00AA);
        axi_read(32'h10, d, r);
        check("ch1_data1", d, 32'h0000_00BB);
        axi_read(32'h10, d, r);
        check("ch1_data_empty", d, 32'd0);
        check("ch1_data_empty_resp", {30'd0, r}, 32'd0);
        axi_read(32'h14, d, r);
        check("ch1_status_after", d, 32'h0001_0000);

        // Flush, and a CTRL write with WSTRB[0]=0 is ignored
        push(1, 16'h0011);
        push(1, 16'h0022);
        axi_write(32'h18, 32'h5, 4'hF, r);
        axi_read(32'h14, d, r);
        check("ch1_flush_status", d, 32'h0001_0000);
        axi_read(32'h18, d, r);
        check("ch1_flush_reads0", d, 32'h1);
        axi_write(32'h18, 32'h0, 4'h0, r);
        check("ch1_nostrb_bresp", {30'd0, r}, 32'd0);
        axi_read(32'h18, d, r);
        check("ch1_nostrb_ctrl", d, 32'h1);

        // Channel 2 overflow and clr_ovf
        axi_write(32'h28, 32'h1, 4'hF, r);
        for (int i = 0; i < 17; i++) push(2, 16'h0200 + 16'(i));
        axi_read(32'h24, d, r);
        check("ch2_status_ovf", d, 32'h0006_0010);
        check("ch2_no_irq", {31'd0, irq}, 32'd0);
        axi_write(32'h28, 32'h9, 4'hF, r);
        axi_read(32'h24, d, r);
        check("ch2_status_clr", d, 32'h0002_0010);
        axi_read(32'h28, d, r);
        check("ch2_ctrl_kept", d, 32'h1);

        // Push and pop in the same cycle on a full FIFO
        @(posedge clk); #1;
        araddr = 32'h20; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 50) begin @(posedge clk); #1; n++; end
        check("ch2_pp_arready", {31'd0, arready}, 32'd1);
        ch_data[2*DATA_W +: DATA_W] = 16'h0300;
        ch_valid[2] = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0; ch_valid = '0;
        check("ch2_pp_rvalid", {31'd0, rvalid}, 32'd1);
        check("ch2_pp_oldest", rdata, 32'h0000_0200);
        axi_read(32'h24, d, r);
        check("ch2_pp_status", d, 32'h0002_0010);
        for (int i = 0; i < 16; i++) begin
            axi_read(32'h20, d, r);
            check("ch2_drain", d, (i < 15) ? (32'h0201 + 32'(i)) : 32'h0300);
        end
        axi_read(32'h24, d, r);
        check("ch2_drained_status", d, 32'h0001_0000);

        // Delayed WVALID, BREADY held low, then irq rise/fall
        @(posedge clk); #1;
        awaddr = 32'h08; wdata = 32'h3; wstrb = 4'hF;
        awvalid = 1'b1; bready = 1'b0; aw_pulses = 0;
        repeat (3) begin @(posedge clk); #1; if (awready) aw_pulses++; end
        wvalid = 1'b1;
        n = 0;
        while (!awready && n < 50) begin @(posedge clk); #1; n++; end
        check("dly_aw_w_ready", {31'd0, awready & wready}, 32'd1);
        if (awready) aw_pulses++;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (awready) aw_pulses++;
            check("dly_bvalid_held", {31'd0, bvalid}, 32'd1);
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1;
        check("dly_bvalid_drop", {31'd0, bvalid}, 32'd0);
        check("dly_aw_pulses", 32'(aw_pulses), 32'd1);
        axi_read(32'h08, d, r);
        check("ch0_ctrl_rb", d, 32'h3);
        check("irq_idle", {31'd0, irq}, 32'd0);
        push(0, 16'h1234);
        check("irq_pre", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_rise", {31'd0, irq}, 32'd1);
        axi_read(32'h00, d, r);
        check("ch0_data", d, 32'h0000_1234);
        check("irq_hold", {31'd0, irq}, 32'd1);
        @(posedge clk); #1;
        check("irq_fall", {31'd0, irq}, 32'd0);

        // Asynchronous reset while a read response is pending
        push(0, 16'h0055);
        @(posedge clk); #1;
        check("rst_pre_irq", {31'd0, irq}, 32'd1);
        rready = 1'b0;
        araddr = 32'h04; arvalid = 1'b1;
        n = 0;
        while (!rvalid && n < 50) begin @(posedge clk); #1; n++; end
        arvalid = 1'b0;
        check("rst_pre_rvalid", {31'd0, rvalid}, 32'd1);
        check("rst_pre_rdata", rdata, 32'h0000_0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_ctl", {29'd0, rvalid, irq, arready}, 32'd0);
        check("rst_async_rdata", rdata, 32'd0);
        rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        axi_read(32'h04, d, r);
        check("rst_ch0_status", d, 32'h0001_0000);
        axi_read(32'h08, d, r);
        check("rst_ch0_ctrl", d, 32'd0);
        axi_read(32'h28, d, r);
        check("rst_ch2_ctrl", d, 32'd0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
